// File: rtl/sig_transition_gen_pkg.sv
// Shared definitions for the transition generator and its detector-side models.
package sig_tx_pkg;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_RISE   = 2'b01;
  localparam logic [1:0] OP_FALL   = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef struct packed {
    logic rise;
    logic fall;
    logic err;
  } strobe_t;

  // Hold counter width; a one-cycle hold still needs a 1-bit register.
  function automatic int hold_w(input int min_hold);
    return (min_hold > 1) ? $clog2(min_hold) : 1;
  endfunction

endpackage

// File: rtl/sig_transition_gen_if.sv
// Command handshake plus generated level and strobes.
interface sig_transition_gen_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       sig_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       err_redundant;

  modport master (
    output cmd_valid, cmd_op,
    input  cmd_ready, sig_out, rise_pulse, fall_pulse, err_redundant
  );

  modport slave (
    input  cmd_valid, cmd_op,
    output cmd_ready, sig_out, rise_pulse, fall_pulse, err_redundant
  );
endinterface

// File: rtl/sig_transition_gen_hold_timer.sv
// Down-counter enforcing the post-change hold window; zero_o means idle.
module hold_timer
  import sig_tx_pkg::*;
#(
  parameter int MIN_HOLD = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  output logic zero_o
);

  localparam int            W        = hold_w(MIN_HOLD);
  localparam logic [W-1:0]  LOAD_VAL = W'(MIN_HOLD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = LOAD_VAL;
    else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sig_transition_gen.sv
// Command-driven level generator with minimum hold time and change strobes.
module sig_transition_gen
  import sig_tx_pkg::*;
#(
  parameter int   MIN_HOLD   = 4,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sig_transition_gen_if.slave  bus
);

  logic    ready;
  logic    accept;
  logic    sig_q, sig_d;
  strobe_t stb_q, stb_d;

  // Only real level changes restart the hold window.
  hold_timer #(.MIN_HOLD(MIN_HOLD)) u_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (stb_d.rise | stb_d.fall),
    .zero_o  (ready)
  );

  assign accept = bus.cmd_valid & ready;

  always_comb begin
    stb_d = '0;
    if (accept) begin
      case (bus.cmd_op)
        OP_RISE:   if (sig_q) stb_d.err  = 1'b1; else stb_d.rise = 1'b1;
        OP_FALL:   if (sig_q) stb_d.fall = 1'b1; else stb_d.err  = 1'b1;
        OP_TOGGLE: if (sig_q) stb_d.fall = 1'b1; else stb_d.rise = 1'b1;
        default:   ;
      endcase
    end
    sig_d = sig_q ^ (stb_d.rise | stb_d.fall);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sig_q <= INIT_LEVEL;
      stb_q <= '0;
    end else begin
      sig_q <= sig_d;
      stb_q <= stb_d;
    end
  end

  assign bus.cmd_ready     = ready;
  assign bus.sig_out       = sig_q;
  assign bus.rise_pulse    = stb_q.rise;
  assign bus.fall_pulse    = stb_q.fall;
  assign bus.err_redundant = stb_q.err;

endmodule

// File: tb/tb_sig_transition_gen.sv
// Scoreboard bench: three generators (hold 4, 1, 8) against a cycle-count reference model.
module tb_sig_transition_gen;
  import sig_tx_pkg::*;

  localparam int MH0 = 4, MH1 = 1, MH2 = 8;

  typedef struct packed {
    logic sig;
    logic rdy;
    logic rise;
    logic fall;
    logic err;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n [3];
  logic       v     [3];
  logic [1:0] op    [3];
  obs_t       act   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sig_transition_gen_if if0 ();
  sig_transition_gen_if if1 ();
  sig_transition_gen_if if2 ();

  assign if0.cmd_valid = v[0];  assign if0.cmd_op = op[0];
  assign if1.cmd_valid = v[1];  assign if1.cmd_op = op[1];
  assign if2.cmd_valid = v[2];  assign if2.cmd_op = op[2];

  assign act[0] = {if0.sig_out, if0.cmd_ready, if0.rise_pulse, if0.fall_pulse, if0.err_redundant};
  assign act[1] = {if1.sig_out, if1.cmd_ready, if1.rise_pulse, if1.fall_pulse, if1.err_redundant};
  assign act[2] = {if2.sig_out, if2.cmd_ready, if2.rise_pulse, if2.fall_pulse, if2.err_redundant};

  sig_transition_gen #(.MIN_HOLD(MH0), .INIT_LEVEL(1'b0)) u_dut0 (.clk(clk), .reset_n(rst_n[0]), .bus(if0.slave));
  sig_transition_gen #(.MIN_HOLD(MH1), .INIT_LEVEL(1'b0)) u_dut1 (.clk(clk), .reset_n(rst_n[1]), .bus(if1.slave));
  sig_transition_gen #(.MIN_HOLD(MH2), .INIT_LEVEL(1'b0)) u_dut2 (.clk(clk), .reset_n(rst_n[2]), .bus(if2.slave));

  task automatic check(input string nm, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, a, e, $time);
    end
  endtask

  function automatic int mh_of(input int d);
    case (d)
      0:       return MH0;
      1:       return MH1;
      default: return MH2;
    endcase
  endfunction

  // ---------------- scoreboard queues ----------------
  obs_t q0[$], q1[$], q2[$];

  function automatic void push(input int d, input obs_t o);
    case (d)
      0:       q0.push_back(o);
      1:       q1.push_back(o);
      default: q2.push_back(o);
    endcase
  endfunction

  function automatic bit pop(input int d, output obs_t o);
    o = '0;
    case (d)
      0:       if (q0.size() > 0) begin o = q0.pop_front(); return 1'b1; end
      1:       if (q1.size() > 0) begin o = q1.pop_front(); return 1'b1; end
      default: if (q2.size() > 0) begin o = q2.pop_front(); return 1'b1; end
    endcase
    return 1'b0;
  endfunction

  // ---------------- reference model ----------------
  // Level plus "earliest cycle a command may be taken"; no counter modelled.
  logic       lvl  [3];
  int         nok  [3];
  logic       pend [3];
  logic [1:0] pop_ [3];
  int         cyc = 0;

  initial begin
    obs_t e;
    for (int d = 0; d < 3; d++) begin lvl[d] = 1'b0; nok[d] = 0; pend[d] = 1'b0; pop_[d] = OP_NOP; end
    forever begin
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rst_n[d] && pend[d] && v[d] && op[d] !== pop_[d]) begin
          errors++;
          $display("FAIL producer_rule dut%0d: op %b changed from %b while stalled", d, op[d], pop_[d]);
        end
        pend[d] = v[d] & ~act[d].rdy;
        pop_[d] = op[d];
        e = '0;
        if (!rst_n[d]) begin
          lvl[d] = 1'b0;
          nok[d] = 0;
        end else if (v[d] && cyc >= nok[d]) begin
          case (op[d])
            OP_RISE:   if (lvl[d]) e.err = 1'b1; else e.rise = 1'b1;
            OP_FALL:   if (lvl[d]) e.fall = 1'b1; else e.err = 1'b1;
            OP_TOGGLE: if (lvl[d]) e.fall = 1'b1; else e.rise = 1'b1;
            default:   ;
          endcase
          if (e.rise) lvl[d] = 1'b1;
          if (e.fall) lvl[d] = 1'b0;
          if (e.rise || e.fall) nok[d] = cyc + mh_of(d);
        end
        e.sig = lvl[d];
        e.rdy = (cyc + 1 >= nok[d]);
        push(d, e);
      end
      cyc++;
    end
  end

  // ---------------- monitor ----------------
  logic lb_req = 1'b0;
  logic lb_en  = 1'b0;
  logic lb_prev = 1'b0;

  initial begin
    obs_t e;
    bit   have;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        have = pop(d, e);
        if (rst_n[d]) begin
          if (!have) check($sformatf("dut%0d_no_expect", d), 8'd0, 8'd1);
          else       check($sformatf("dut%0d_obs{sig,rdy,rise,fall,err}", d), 8'(act[d]), 8'(e));
          check($sformatf("dut%0d_strobe_onehot", d),
                8'($countones({act[d].rise, act[d].fall, act[d].err}) <= 1), 8'd1);
        end
      end
      // Loopback: a same-cycle edge detector on sig_out must agree with the strobes.
      if (!lb_req) lb_en = 1'b0;
      else if (!lb_en) begin
        lb_prev = act[0].sig;
        lb_en   = 1'b1;
      end else begin
        check("loopback_rise", 8'(act[0].rise), 8'(act[0].sig & ~lb_prev));
        check("loopback_fall", 8'(act[0].fall), 8'(~act[0].sig & lb_prev));
        lb_prev = act[0].sig;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int d, input logic [1:0] o);
    bit r;
    v[d]  = 1'b1;
    op[d] = o;
    for (int i = 0; i < 40; i++) begin
      r = act[d].rdy;
      @(negedge clk);
      if (r) return;
    end
    check($sformatf("dut%0d_send_timeout", d), 8'd0, 8'd1);
  endtask

  task automatic idle(input int d, input int n);
    v[d] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int   n;
    int   guard;
    logic rdy_prev;
    for (int d = 0; d < 3; d++) begin rst_n[d] = 1'b1; v[d] = 1'b0; op[d] = OP_NOP; end

    #1;
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b0;
    #1;
    for (int d = 0; d < 3; d++)
      check($sformatf("dut%0d_reset_state", d), 8'(act[d]), 8'b01000);
    @(posedge clk); #2;
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    @(negedge clk);

    // Hold 4: RISE, then FALL held valid through the hold window.
    idle(0, 3);
    send(0, OP_RISE);
    check("dut0_ready_low_after_rise", 8'(act[0].rdy), 8'd0);
    send(0, OP_FALL);
    idle(0, 4);
    // Redundant RISE while high: error strobe only.
    send(0, OP_RISE);
    idle(0, 4);
    send(0, OP_RISE);
    check("dut0_redundant_err", 8'(act[0].err), 8'd1);
    check("dut0_redundant_ready", 8'(act[0].rdy), 8'd1);
    send(0, OP_NOP);
    send(0, OP_FALL);
    idle(0, 4);
    send(0, OP_FALL);
    idle(0, 2);

    // Hold 1: back-to-back toggles.
    repeat (6) send(1, OP_TOGGLE);
    idle(1, 2);

    // Hold 8: async reset three cycles into the hold window.
    send(2, OP_RISE);
    v[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("dut2_high_in_hold", 8'({act[2].sig, act[2].rdy}), 8'b10);
    @(posedge clk); #2;
    rst_n[2] = 1'b0;
    #1;
    check("dut2_async_reset_obs", 8'(act[2]), 8'b01000);
    @(posedge clk); #2;
    rst_n[2] = 1'b1;
    @(negedge clk);
    idle(2, 2);

    // Random traffic on hold 4 with loopback checking.
    lb_req   = 1'b1;
    rdy_prev = act[0].rdy;
    n = 0;
    guard = 0;
    while (n < 200 && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (!(v[0] && !rdy_prev)) begin
        if (v[0]) n++;
        v[0]  = ($urandom_range(0, 3) != 0);
        op[0] = 2'($urandom_range(0, 3));
      end
      rdy_prev = act[0].rdy;
    end
    if (n < 200) check("random_cmd_budget", 8'd0, 8'd1);
    idle(0, 10);
    @(posedge clk); #2;
    lb_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sig_transition_gen.md
# sig_transition_gen

Transmit-side companion to the signal-transition detector. It accepts transition commands over a valid/ready handshake and drives one level output accordingly. After every level change it enforces a programmable minimum hold time before the next change. Each real change is reported with one-cycle rise/fall strobes, so a downstream transition detector and this block agree cycle-for-cycle.

## Interface
Parameters:
- MIN_HOLD, 4, minimum cycles `sig_out` stays stable after a change; legal range ≥ 1
- INIT_LEVEL, 1'b0, `sig_out` value during and after reset

Ports:
- clk  in  1  single clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_op  in  2  00 NOP, 01 RISE, 10 FALL, 11 TOGGLE
- cmd_ready  out  1  block can accept a command this cycle
- sig_out  out  1  generated level (registered)
- rise_pulse  out  1  one-cycle strobe, high in the first cycle `sig_out` is 1 after a 0→1 change
- fall_pulse  out  1  one-cycle strobe, high in the first cycle `sig_out` is 0 after a 1→0 change
- err_redundant  out  1  one-cycle strobe: accepted RISE while already high, or FALL while already low

## Operation
- Command is accepted on a posedge where `cmd_valid && cmd_ready`. No other edge consumes a command.
- Effective op on acceptance:
  - RISE with `sig_out`=0: set to 1.
  - FALL with `sig_out`=1: clear to 0.
  - TOGGLE: invert.
  - NOP: nothing.
  - RISE with `sig_out`=1, or FALL with `sig_out`=0: no change, `err_redundant`=1 next cycle.
- States:
  - READY (`hold_cnt`==0). `cmd_ready`=1.
  - HOLD (`hold_cnt`≠0). `cmd_ready`=0. `hold_cnt` decrements by 1 per cycle. Returns to READY when it reaches 0.
- A real change loads `hold_cnt` with MIN_HOLD−1. With MIN_HOLD=1 the block never leaves READY, so back-to-back changes are legal.
- NOP and redundant commands do not load `hold_cnt` and do not drop `cmd_ready`.
- Producer rule: `cmd_op` is stable while `cmd_valid && !cmd_ready`. The bench asserts this.
- `cmd_valid` low in READY: state holds and all strobes are 0.
- Width: `hold_cnt` is $clog2(MIN_HOLD) bits, minimum 1 bit. It never underflows; decrement happens only when it is non-zero.

## Timing
- Reset (async assert, sync release by the system): `sig_out`=INIT_LEVEL, `hold_cnt`=0, `cmd_ready`=1, `rise_pulse`=`fall_pulse`=`err_redundant`=0.
- Reset asserted mid-HOLD aborts the hold. `sig_out` returns to INIT_LEVEL immediately, without waiting for a clock. No strobe is produced.
- Latency: a command accepted at edge T changes `sig_out` after edge T. The strobe is high in cycle T..T+1, coincident with the new level.
- Earliest next accepting edge after a change at T is T+MIN_HOLD. `cmd_ready` is low for exactly MIN_HOLD−1 cycles.
- `cmd_ready` is a combinational decode of `hold_cnt` only. It has no path from `cmd_valid` or `cmd_op`.
- All other outputs are registered.
- At most one of `rise_pulse`, `fall_pulse`, `err_redundant` is high in any cycle.

## Structure
- Shared package `sig_tx_pkg`: op encodings OP_NOP/OP_RISE/OP_FALL/OP_TOGGLE as 2-bit localparams. The detector side uses the same package for the bench model.
- One natural sub-module: `hold_timer`.
  - Inputs: load strobe, load value MIN_HOLD−1.
  - Behaviour: decrement to zero.
  - Output: `zero` flag, which drives `cmd_ready`.
- The top holds the op decode, the `sig_out` register and the strobe registers.

## Test plan
- Reset behaviour: drive reset_n low with INIT_LEVEL=0, then release. Required: `sig_out`=0, `cmd_ready`=1, all strobes 0.
- RISE then hold window: MIN_HOLD=4, RISE accepted at edge 5. Required:
  - `sig_out`=1 and `rise_pulse`=1 in the following cycle.
  - `cmd_ready` low for cycles 6–8.
  - FALL held valid is accepted at edge 9; `fall_pulse` follows.
- Redundant command: RISE while `sig_out`=1. Required: `err_redundant` one cycle, `sig_out` unchanged, `cmd_ready` stays 1.
- Back-to-back toggles: MIN_HOLD=1, TOGGLE on every edge for 6 cycles. Required: `sig_out` alternates every cycle, with alternating rise/fall strobes.
- Reset mid-HOLD: MIN_HOLD=8, assert reset_n 3 cycles after a RISE. Required: `sig_out`=INIT_LEVEL without waiting for a clock, `cmd_ready`=1 after release.
- Loopback: feed `sig_out` into the detector. Required: the detector's rise/fall outputs match this block's strobes with a fixed offset over 200 random commands.
